ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/apple1_pkg.sv | 28 ++
 rtl/ram_loader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/apple1_pkg.sv
// Shared definitions for the Apple-1 RAM loader: FSM encoding and header byte layout.
package apple1_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StHdr2,
    StHdr3,
    StWrite,
    StDrain,
    StVaddr,
    StVwait,
    StFin
  } state_e;

  // Position of each header byte in the captured header array.
  localparam logic [1:0] HdrBaseLo = 2'd0;
  localparam logic [1:0] HdrBaseHi = 2'd1;
  localparam logic [1:0] HdrLenLo  = 2'd2;
  localparam logic [1:0] HdrLenHi  = 2'd3;

  // States in which the loader consumes bytes from the input stream.
  function automatic logic stream_state(state_e s);
    return s inside {StHdr0, StHdr1, StHdr2, StHdr3, StWrite, StDrain};
  endfunction

endpackage

// File: rtl/ram_loader.sv
// Streams a header-framed image into RAM, then optionally re-reads it and
// compares 8-bit checksums of written and read bytes.
module ram_loader
  import apple1_pkg::*;
#(
  parameter logic [15:0] RAM_TOP = 16'hBFFF,
  parameter int          VERIFY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [15:0] address,
  output logic        w_en,
  output logic [7:0]  din,
  input  logic [7:0]  dout,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_e          state_q;
  logic [3:0][7:0] hdr_q;
  logic [15:0]     cnt_q, addr_q;
  logic [7:0]      din_q, wsum_q, rsum_q;
  logic            w_en_q, busy_q, done_q, err_q;
  // Read pipeline: v0 marks an address issued, v1 marks its dout arriving next cycle.
  logic            v0_q, v1_q;

  logic            accept;
  logic [15:0]     base, len, hdr_len;
  logic [16:0]     hdr_end;
  logic            last_byte;
  logic [7:0]      rsum_final;

  always_comb begin
    s_ready    = stream_state(state_q);
    accept     = s_valid & s_ready;
    base       = {hdr_q[HdrBaseHi], hdr_q[HdrBaseLo]};
    len        = {hdr_q[HdrLenHi], hdr_q[HdrLenLo]};
    hdr_len    = {s_data, hdr_q[HdrLenLo]};
    hdr_end    = {1'b0, base} + {1'b0, hdr_len} - 17'd1;
    last_byte  = (cnt_q == len - 16'd1);
    rsum_final = rsum_q + (v1_q ? dout : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hdr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wsum_q  <= '0;
      rsum_q  <= '0;
      w_en_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      w_en_q <= 1'b0;
      done_q <= 1'b0;
      v0_q   <= 1'b0;
      v1_q   <= v0_q;
      if (v1_q) rsum_q <= rsum_q + dout;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StHdr0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wsum_q  <= '0;
            rsum_q  <= '0;
          end
        end
        StHdr0: if (accept) begin
          hdr_q[HdrBaseLo] <= s_data;
          state_q          <= StHdr1;
        end
        StHdr1: if (accept) begin
          hdr_q[HdrBaseHi] <= s_data;
          state_q          <= StHdr2;
        end
        StHdr2: if (accept) begin
          hdr_q[HdrLenLo] <= s_data;
          state_q         <= StHdr3;
        end
        StHdr3: if (accept) begin
          hdr_q[HdrLenHi] <= s_data;
          if (hdr_len == 16'd0) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else if (hdr_end > {1'b0, RAM_TOP}) begin
            err_q   <= 1'b1;
            state_q <= StDrain;
          end else begin
            state_q <= StWrite;
          end
        end
        StWrite: if (accept) begin
          addr_q <= base + cnt_q;
          din_q  <= s_data;
          w_en_q <= 1'b1;
          wsum_q <= wsum_q + s_data;
          cnt_q  <= cnt_q + 16'd1;
          if (last_byte) begin
            cnt_q <= '0;
            if (VERIFY != 0) begin
              state_q <= StVaddr;
            end else begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end
          end
        end
        StDrain: if (accept) begin
          cnt_q <= cnt_q + 16'd1;
          if (last_byte) begin
            cnt_q   <= '0;
            state_q <= StFin;
            done_q  <= 1'b1;
          end
        end
        StVaddr: begin
          addr_q <= base + cnt_q;
          v0_q   <= 1'b1;
          cnt_q  <= cnt_q + 16'd1;
          if (last_byte) begin
            cnt_q   <= '0;
            state_q <= StVwait;
          end
        end
        StVwait: begin
          // Once no address is in flight, the final dout is on the bus this cycle.
          if (!v0_q) begin
            if (rsum_final != wsum_q) err_q <= 1'b1;
            state_q <= StFin;
            done_q  <= 1'b1;
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign address = addr_q;
  assign w_en    = w_en_q;
  assign din     = din_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = err_q;

endmodule
